// File: rtl/hs_perf_pkg.sv
// Shared types, read-select codes and saturating arithmetic for hs_perf_monitor.
// Optional min/max latency tracking is enabled by defining HS_PERF_MINMAX_EN.
package hs_perf_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } ch_state_e;

  localparam logic [3:0] RD_SEL_TXN       = 4'd0;
  localparam logic [3:0] RD_SEL_READY     = 4'd1;
  localparam logic [3:0] RD_SEL_LAST_LAT  = 4'd2;
  localparam logic [3:0] RD_SEL_TOTAL_LAT = 4'd3;
  localparam logic [3:0] RD_SEL_STALL     = 4'd4;
  localparam logic [3:0] RD_SEL_LAST_II   = 4'd5;
  localparam logic [3:0] RD_SEL_STATUS    = 4'd6;
  localparam logic [3:0] RD_SEL_MIN_LAT   = 4'd7;
  localparam logic [3:0] RD_SEL_MAX_LAT   = 4'd8;

  // Operands are zero-extended to MAX_W; w is the real counter width.
  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic sat_add_ovf(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned      w);
    logic [MAX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > {1'b0, sat_max(w)};
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      w);
    if (sat_add_ovf(a, b, w)) return sat_max(w);
    return a + b;
  endfunction

  function automatic logic sat_inc_ovf(input logic [MAX_W-1:0] a,
                                       input int unsigned      w);
    return sat_add_ovf(a, MAX_W'(1), w);
  endfunction

  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] a,
                                               input int unsigned      w);
    return sat_add(a, MAX_W'(1), w);
  endfunction

endpackage

// File: rtl/hs_perf_monitor_channel.sv
// One ap_ctrl_hs channel: IDLE/ACTIVE/HOLD tracker plus its saturating counters.
// min/max latency registers exist only when HS_PERF_MINMAX_EN is defined.
module hs_perf_channel
  import hs_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_ready,
  input  logic             i_done,
  input  logic             i_continue,
  input  logic             i_finish,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_txn_cnt,
  output logic [CNT_W-1:0] o_ready_cnt,
  output logic [CNT_W-1:0] o_last_lat,
  output logic [CNT_W-1:0] o_total_lat,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_last_ii,
  output logic [CNT_W-1:0] o_min_lat,
  output logic [CNT_W-1:0] o_max_lat,
  output logic [1:0]       o_state,
  output logic             o_ovf
);

  ch_state_e        r_state;
  logic             r_seen_start;
  logic             r_ovf;
  logic [CNT_W-1:0] r_lat_run;
  logic [CNT_W-1:0] r_ii_run;
  logic [CNT_W-1:0] r_txn_cnt;
  logic [CNT_W-1:0] r_ready_cnt;
  logic [CNT_W-1:0] r_last_lat;
  logic [CNT_W-1:0] r_total_lat;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_last_ii;

  logic             w_start;
  logic             w_complete;
  logic             w_ovf_set;
  logic [CNT_W-1:0] w_cmp_lat;
  logic [CNT_W-1:0] w_lat_n;
  logic [CNT_W-1:0] w_ii_n;
  logic [CNT_W-1:0] w_txn_n;
  logic [CNT_W-1:0] w_rdy_n;
  logic [CNT_W-1:0] w_tot_n;
  logic [CNT_W-1:0] w_stl_n;

  function automatic logic [MAX_W-1:0] zx(input logic [CNT_W-1:0] v);
    return MAX_W'(v);
  endfunction

  always_comb begin
    w_start    = (r_state == IDLE) && i_start;
    w_lat_n    = CNT_W'(sat_inc(zx(r_lat_run), CNT_W));
    w_ii_n     = CNT_W'(sat_inc(zx(r_ii_run), CNT_W));
    w_txn_n    = CNT_W'(sat_inc(zx(r_txn_cnt), CNT_W));
    w_rdy_n    = CNT_W'(sat_inc(zx(r_ready_cnt), CNT_W));
    w_stl_n    = CNT_W'(sat_inc(zx(r_stall_cnt), CNT_W));
    w_complete = 1'b0;
    w_cmp_lat  = '0;
    case (r_state)
      IDLE: begin
        if (i_start && i_done && i_continue) begin
          w_complete = 1'b1;
          w_cmp_lat  = CNT_W'(1);
        end
      end
      ACTIVE: begin
        // Done cycle counts toward latency, hence the incremented value.
        if (i_done && i_continue) begin
          w_complete = 1'b1;
          w_cmp_lat  = w_lat_n;
        end
      end
      HOLD: begin
        if (i_continue) begin
          w_complete = 1'b1;
          w_cmp_lat  = r_lat_run;
        end
      end
      default: ;
    endcase
    w_tot_n   = CNT_W'(sat_add(zx(r_total_lat), zx(w_cmp_lat), CNT_W));
    w_ovf_set = (w_complete && (sat_inc_ovf(zx(r_txn_cnt), CNT_W) ||
                                sat_add_ovf(zx(r_total_lat), zx(w_cmp_lat), CNT_W))) ||
                (i_ready && sat_inc_ovf(zx(r_ready_cnt), CNT_W)) ||
                ((r_state == HOLD) && !i_continue && sat_inc_ovf(zx(r_stall_cnt), CNT_W)) ||
                ((r_state == ACTIVE) && sat_inc_ovf(zx(r_lat_run), CNT_W)) ||
                (r_seen_start && !w_start && sat_inc_ovf(zx(r_ii_run), CNT_W));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_seen_start <= 1'b0;
      r_ovf        <= 1'b0;
      r_lat_run    <= '0;
      r_ii_run     <= '0;
      r_txn_cnt    <= '0;
      r_ready_cnt  <= '0;
      r_last_lat   <= '0;
      r_total_lat  <= '0;
      r_stall_cnt  <= '0;
      r_last_ii    <= '0;
    end else if (i_clear) begin
      r_state      <= IDLE;
      r_seen_start <= 1'b0;
      r_ovf        <= 1'b0;
      r_lat_run    <= '0;
      r_ii_run     <= '0;
      r_txn_cnt    <= '0;
      r_ready_cnt  <= '0;
      r_last_lat   <= '0;
      r_total_lat  <= '0;
      r_stall_cnt  <= '0;
      r_last_ii    <= '0;
    end else if (!i_finish) begin
      if (i_ready) r_ready_cnt <= w_rdy_n;
      // ii_run restarts at 1 on each start so the next start sees the gap.
      if (w_start) begin
        r_seen_start <= 1'b1;
        r_ii_run     <= CNT_W'(1);
        if (r_seen_start) r_last_ii <= r_ii_run;
      end else if (r_seen_start) begin
        r_ii_run <= w_ii_n;
      end
      case (r_state)
        IDLE: begin
          if (i_start && !(i_done && i_continue)) begin
            r_state   <= i_done ? HOLD : ACTIVE;
            r_lat_run <= CNT_W'(1);
          end
        end
        ACTIVE: begin
          r_lat_run <= w_lat_n;
          if (i_done) r_state <= i_continue ? IDLE : HOLD;
        end
        HOLD: begin
          if (i_continue) r_state <= IDLE;
          else            r_stall_cnt <= w_stl_n;
        end
        default: r_state <= IDLE;
      endcase
      if (w_complete) begin
        r_txn_cnt   <= w_txn_n;
        r_last_lat  <= w_cmp_lat;
        r_total_lat <= w_tot_n;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

`ifdef HS_PERF_MINMAX_EN
  logic [CNT_W-1:0] r_min_lat;
  logic [CNT_W-1:0] r_max_lat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_min_lat <= '0;
      r_max_lat <= '0;
    end else if (i_clear) begin
      r_min_lat <= '0;
      r_max_lat <= '0;
    end else if (!i_finish && w_complete) begin
      if ((r_txn_cnt == '0) || (w_cmp_lat < r_min_lat)) r_min_lat <= w_cmp_lat;
      if (w_cmp_lat > r_max_lat) r_max_lat <= w_cmp_lat;
    end
  end

  assign o_min_lat = r_min_lat;
  assign o_max_lat = r_max_lat;
`else
  assign o_min_lat = '0;
  assign o_max_lat = '0;
`endif

  assign o_txn_cnt   = r_txn_cnt;
  assign o_ready_cnt = r_ready_cnt;
  assign o_last_lat  = r_last_lat;
  assign o_total_lat = r_total_lat;
  assign o_stall_cnt = r_stall_cnt;
  assign o_last_ii   = r_last_ii;
  assign o_state     = r_state;
  assign o_ovf       = r_ovf;

endmodule

// File: rtl/hs_perf_monitor.sv
// Top of the handshake performance monitor: NUM_CH channel trackers plus a registered read port.
// Define HS_PERF_MINMAX_EN to add per-channel min/max latency registers.
module hs_perf_monitor
  import hs_perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [3:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic              any_ovf
);

  logic [CNT_W-1:0]  w_txn      [NUM_CH];
  logic [CNT_W-1:0]  w_ready    [NUM_CH];
  logic [CNT_W-1:0]  w_last_lat [NUM_CH];
  logic [CNT_W-1:0]  w_total    [NUM_CH];
  logic [CNT_W-1:0]  w_stall    [NUM_CH];
  logic [CNT_W-1:0]  w_last_ii  [NUM_CH];
  logic [CNT_W-1:0]  w_min_lat  [NUM_CH];
  logic [CNT_W-1:0]  w_max_lat  [NUM_CH];
  logic [1:0]        w_state    [NUM_CH];
  logic [NUM_CH-1:0] w_ovf;
  logic [CNT_W-1:0]  w_rd_mux;
  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_rd_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hs_perf_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_start    (ap_start[g]),
      .i_ready    (ap_ready[g]),
      .i_done     (ap_done[g]),
      .i_continue (ap_continue[g]),
      .i_finish   (finish),
      .i_clear    (clear),
      .o_txn_cnt  (w_txn[g]),
      .o_ready_cnt(w_ready[g]),
      .o_last_lat (w_last_lat[g]),
      .o_total_lat(w_total[g]),
      .o_stall_cnt(w_stall[g]),
      .o_last_ii  (w_last_ii[g]),
      .o_min_lat  (w_min_lat[g]),
      .o_max_lat  (w_max_lat[g]),
      .o_state    (w_state[g]),
      .o_ovf      (w_ovf[g])
    );
    assign busy[g] = (w_state[g] != IDLE);
  end

  always_comb begin
    w_rd_mux = '0;
    if (int'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        RD_SEL_TXN:       w_rd_mux = w_txn[rd_ch];
        RD_SEL_READY:     w_rd_mux = w_ready[rd_ch];
        RD_SEL_LAST_LAT:  w_rd_mux = w_last_lat[rd_ch];
        RD_SEL_TOTAL_LAT: w_rd_mux = w_total[rd_ch];
        RD_SEL_STALL:     w_rd_mux = w_stall[rd_ch];
        RD_SEL_LAST_II:   w_rd_mux = w_last_ii[rd_ch];
        RD_SEL_STATUS:    w_rd_mux = CNT_W'({w_ovf[rd_ch], w_state[rd_ch]});
        RD_SEL_MIN_LAT:   w_rd_mux = w_min_lat[rd_ch];
        RD_SEL_MAX_LAT:   w_rd_mux = w_max_lat[rd_ch];
        default:          w_rd_mux = '0;
      endcase
    end
  end

  // Read stage: sample the counters as they stand before this cycle's update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign any_ovf  = |w_ovf;

endmodule

// File: tb/tb_hs_perf_monitor.sv
// Directed bench for hs_perf_monitor: a 4-channel 32-bit instance and a 3-channel 4-bit instance.
module tb_hs_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [3:0]  a_start, a_ready, a_done, a_cont, a_busy;
  logic        a_finish, a_clear, a_rd_en, a_rd_valid, a_any_ovf;
  logic [1:0]  a_rd_ch;
  logic [3:0]  a_rd_sel;
  logic [31:0] a_rd_data;

  logic [2:0]  b_start, b_ready, b_done, b_cont, b_busy;
  logic        b_finish, b_clear, b_rd_en, b_rd_valid, b_any_ovf;
  logic [1:0]  b_rd_ch;
  logic [3:0]  b_rd_sel;
  logic [3:0]  b_rd_data;

  always #5 clk = ~clk;

  hs_perf_monitor #(.NUM_CH(4), .CNT_W(32)) u_dut_a (
    .clock(clk), .reset(rst_n), .ap_start(a_start), .ap_ready(a_ready),
    .ap_done(a_done), .ap_continue(a_cont), .finish(a_finish), .clear(a_clear),
    .rd_en(a_rd_en), .rd_ch(a_rd_ch), .rd_sel(a_rd_sel), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data), .busy(a_busy), .any_ovf(a_any_ovf)
  );

  hs_perf_monitor #(.NUM_CH(3), .CNT_W(4)) u_dut_b (
    .clock(clk), .reset(rst_n), .ap_start(b_start), .ap_ready(b_ready),
    .ap_done(b_done), .ap_continue(b_cont), .finish(b_finish), .clear(b_clear),
    .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_sel(b_rd_sel), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .busy(b_busy), .any_ovf(b_any_ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd_a(input string tag, input int ch, input int sel, input logic [31:0] exp);
    a_rd_en  = 1'b1;
    a_rd_ch  = 2'(ch);
    a_rd_sel = 4'(sel);
    tick;
    a_rd_en = 1'b0;
    check({tag, "_vld"}, 32'(a_rd_valid), 32'd1);
    check(tag, a_rd_data, exp);
  endtask

  task automatic rd_b(input string tag, input int ch, input int sel, input logic [31:0] exp);
    b_rd_en  = 1'b1;
    b_rd_ch  = 2'(ch);
    b_rd_sel = 4'(sel);
    tick;
    b_rd_en = 1'b0;
    check(tag, 32'(b_rd_data), exp);
  endtask

  // Transaction of the given latency (start cycle to done cycle inclusive), continue high.
  task automatic txn_a(input int ch, input int lat);
    a_start[ch] = 1'b1;
    if (lat == 1) a_done[ch] = 1'b1;
    tick;
    a_start[ch] = 1'b0;
    a_done[ch]  = 1'b0;
    if (lat > 1) begin
      repeat (lat - 2) tick;
      a_done[ch] = 1'b1;
      tick;
      a_done[ch] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] exp_min, exp_max;
`ifdef HS_PERF_MINMAX_EN
    exp_min = 32'd2;
    exp_max = 32'd9;
`else
    exp_min = 32'd0;
    exp_max = 32'd0;
`endif
    rst_n = 1'b0;
    a_start = '0; a_ready = '0; a_done = '0; a_cont = 4'hF;
    a_finish = 0; a_clear = 0; a_rd_en = 0; a_rd_ch = '0; a_rd_sel = '0;
    b_start = '0; b_ready = '0; b_done = '0; b_cont = 3'h7;
    b_finish = 0; b_clear = 0; b_rd_en = 0; b_rd_ch = '0; b_rd_sel = '0;
    #1;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_rd_valid", 32'(a_rd_valid), 0);
    check("rst_rd_data", a_rd_data, 0);
    check("rst_any_ovf", 32'(a_any_ovf), 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Ch0: latency 10
    a_start[0] = 1'b1;
    tick;
    a_start[0] = 1'b0;
    check("ch0_busy_after_start", 32'(a_busy[0]), 1);
    repeat (8) tick;
    check("ch0_busy_before_done", 32'(a_busy[0]), 1);
    a_done[0] = 1'b1;
    tick;
    a_done[0] = 1'b0;
    check("ch0_busy_after_done", 32'(a_busy[0]), 0);
    check("rd_valid_idle", 32'(a_rd_valid), 0);
    rd_a("ch0_txn", 0, 0, 1);
    rd_a("ch0_last_lat", 0, 2, 10);
    rd_a("ch0_total_lat", 0, 3, 10);

    // Ch1: start and done in the same cycle
    a_start[1] = 1'b1; a_done[1] = 1'b1;
    tick;
    a_start[1] = 1'b0; a_done[1] = 1'b0;
    check("ch1_busy", 32'(a_busy[1]), 0);
    rd_a("ch1_last_lat", 1, 2, 1);
    rd_a("ch1_status", 1, 6, 0);

    // Ch2: latency 3, then 5 held cycles with continue low
    a_start[2] = 1'b1;
    tick;
    a_start[2] = 1'b0;
    tick;
    a_done[2] = 1'b1; a_cont[2] = 1'b0;
    tick;
    a_done[2] = 1'b0;
    rd_a("ch2_status_hold", 2, 6, 2);
    rd_a("ch2_txn_hold", 2, 0, 0);
    repeat (3) tick;
    a_cont[2] = 1'b1;
    tick;
    rd_a("ch2_stall", 2, 4, 5);
    rd_a("ch2_txn", 2, 0, 1);
    rd_a("ch2_last_lat", 2, 2, 3);

    // Ch0: three starts 7 cycles apart; ch3 ready for 3 cycles
    txn_a(0, 1); repeat (6) tick;
    txn_a(0, 1); repeat (6) tick;
    txn_a(0, 1);
    a_ready[3] = 1'b1;
    repeat (3) tick;
    a_ready[3] = 1'b0;
    rd_a("ch0_last_ii", 0, 5, 7);
    rd_a("ch3_ready", 3, 1, 3);

    // Frozen: transaction and ready pulses must not count
    a_finish = 1'b1;
    txn_a(0, 4);
    check("frozen_busy", 32'(a_busy[0]), 0);
    a_ready[3] = 1'b1;
    tick; tick;
    a_ready[3] = 1'b0;
    rd_a("frozen_txn", 0, 0, 4);
    rd_a("frozen_last_lat", 0, 2, 1);
    rd_a("frozen_total", 0, 3, 13);
    rd_a("frozen_ii", 0, 5, 7);
    rd_a("frozen_ready", 3, 1, 3);
    a_finish = 1'b0;

    // Min/max on ch3
    rd_a("ch3_min_empty", 3, 7, 0);
    txn_a(3, 4);
    txn_a(3, 2);
    txn_a(3, 9);
    rd_a("ch3_min_lat", 3, 7, exp_min);
    rd_a("ch3_max_lat", 3, 8, exp_max);
    rd_a("ch3_sel9", 3, 9, 0);
    rd_a("ch3_total", 3, 3, 15);
    check("a_no_ovf", 32'(a_any_ovf), 0);

    // 4-bit instance: 16 completions of latency 3 saturate
    for (int i = 0; i < 16; i++) begin
      b_start[0] = 1'b1;
      tick;
      b_start[0] = 1'b0;
      tick;
      b_done[0] = 1'b1;
      tick;
      b_done[0] = 1'b0;
    end
    check("b_any_ovf_set", 32'(b_any_ovf), 1);
    rd_b("b_txn_sat", 0, 0, 15);
    rd_b("b_total_sat", 0, 3, 15);
    rd_b("b_last_lat", 0, 2, 3);
    rd_b("b_status_ovf", 0, 6, 4);
    rd_b("b_last_ii", 0, 5, 3);
    rd_b("b_bad_ch", 3, 0, 0);
    b_clear = 1'b1;
    tick;
    b_clear = 1'b0;
    check("b_any_ovf_clr", 32'(b_any_ovf), 0);
    check("b_busy_clr", 32'(b_busy), 0);
    rd_b("b_txn_clr", 0, 0, 0);
    rd_b("b_total_clr", 0, 3, 0);
    rd_b("b_status_clr", 0, 6, 0);

    // Asynchronous reset while ch0 is ACTIVE
    rd_a("pre_rst_total", 0, 3, 13);
    a_start[0] = 1'b1;
    tick;
    a_start[0] = 1'b0;
    check("pre_rst_busy", 32'(a_busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(a_busy), 0);
    check("async_rst_rd_data", a_rd_data, 0);
    check("async_rst_rd_valid", 32'(a_rd_valid), 0);
    tick;
    rst_n = 1'b1;
    tick;
    rd_a("post_rst_txn", 0, 0, 0);
    rd_a("post_rst_total", 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_perf_monitor.md
Name: hs_perf_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only block-level handshake status monitor.
- Observes NUM_CH ap_ctrl_hs channels (ap_start/ap_ready/ap_done/ap_continue) in parallel, one per top module, pipelined loop or sub-function.
- Accumulates per-channel performance counters: transactions, latency, initiation interval, stall cycles.
- Exposes the counters through a 1-cycle-latency read port, so the same statistics are available on hardware builds without CSV dumping.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16).
- CNT_W, 32, width of every counter and of rd_data.
- CH_W, $clog2(NUM_CH) min 1, width of rd_ch.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- ap_start  in  NUM_CH  per-channel start, observed.
- ap_ready  in  NUM_CH  per-channel ready, observed.
- ap_done  in  NUM_CH  per-channel done, observed.
- ap_continue  in  NUM_CH  per-channel continue; tie to 1 for channels without continue.
- finish  in  1  while 1, all counters and FSMs freeze; reads still served.
- clear  in  1  synchronous clear of all counters, FSMs and sticky bits.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  channel to read.
- rd_sel  in  4  counter select.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- busy  out  NUM_CH  channel FSM not in IDLE.
- any_ovf  out  1  OR of all per-channel overflow sticky bits.

Behaviour:
- Reset (reset=0, asynchronous): all FSMs IDLE, all counters 0, rd_valid=0, rd_data=0, busy=0, any_ovf=0. Reset asserted mid-transaction discards the partial transaction.
- Per-channel FSM: IDLE, ACTIVE, HOLD.
  - IDLE: ap_start=1 accepts a transaction (start event).
    - If ap_done&ap_continue in the same cycle: complete, latency 1, stay IDLE.
    - If ap_done&!ap_continue: go to HOLD.
    - Otherwise: go to ACTIVE, lat_run=1.
  - ACTIVE: lat_run+1 each cycle. ap_done&ap_continue completes and returns to IDLE; ap_done&!ap_continue goes to HOLD. Recorded latency = cycles from start cycle to done cycle inclusive.
  - HOLD: stall_cnt+1 each cycle continue=0. On continue=1, complete and go to IDLE.
- Completion updates: txn_cnt+1; last_lat=latency; total_lat+=latency.
- ready_cnt+1 on every cycle ap_ready=1, in any state.
- last_ii = cycles between consecutive start events. Before the second start, last_ii=0. ii_run counts from each start event.
- All counters saturate at 2^CNT_W-1. Any saturating event sets the channel's sticky ovf bit; it clears only on clear or reset.
- Priority: reset > clear > finish freeze > normal update. Clear in the same cycle as done: the clear wins and the event is lost.
- Read: rd_en in cycle t gives rd_valid=1 and rd_data in t+1. Data is the value registered at the end of t, before that cycle's update. rd_valid=0 otherwise; rd_data holds its last value.
- rd_sel map: 0 txn_cnt, 1 ready_cnt, 2 last_lat, 3 total_lat, 4 stall_cnt, 5 last_ii, 6 status {ovf at bit 2, state[1:0]: IDLE=0 ACTIVE=1 HOLD=2}, 7 min_lat, 8 max_lat. Other values read 0.
- rd_ch >= NUM_CH reads 0.

Optional Feature:
- Macro: HS_PERF_MINMAX_EN.
- Defined: per-channel min_lat and max_lat registers updated on completion. min_lat reads 0 while txn_cnt=0.
- Undefined: no min/max registers; rd_sel 7 and 8 read 0.

Decomposition:
- Package hs_perf_pkg holds:
  - ch_state_e enum (IDLE, ACTIVE, HOLD).
  - RD_SEL_* constants 0..8.
  - sat_inc and sat_add functions parameterised on CNT_W.
- Sub-module hs_perf_channel: one FSM plus its counters, generated NUM_CH times.
- Top holds the read mux, read pipeline register, and the busy/any_ovf reduction.

Test Plan:
- Ch0 start pulse at t0, done&continue at t0+9 -> txn_cnt=1, last_lat=10, total_lat=10, busy[0] high for 10 cycles.
- Ch1 start and done in the same cycle with continue=1 -> last_lat=1, state stays IDLE, busy[1] never asserts.
- Ch2 done with continue=0 held for 5 cycles -> stall_cnt=5, status read 2 during HOLD, txn_cnt increments only when continue rises.
- Ch0 starts at t=10, 17, 24 -> last_ii=7. Assert finish, then run another transaction -> all counters unchanged, reads return frozen values.
- CNT_W=4: 16 completions of latency 3 -> txn_cnt=15 saturated, total_lat=15, any_ovf=1. Then clear -> all 0, any_ovf=0.
- With HS_PERF_MINMAX_EN: latencies 4, 2, 9 -> min_lat=2, max_lat=9. Without the macro: sel 7/8 read 0. Also: reset=0 mid-ACTIVE -> everything 0 immediately, no clock needed.
